// File: rtl/pulse_period_meter_if.sv
// pulse_period_meter_if -- signal bundle between a pulse period meter and its user.
//   sig_in       : square-wave input, asynchronous to the meter clock
//   period_out   : last measured rise-to-rise period, in clock cycles
//   high_out     : last measured rise-to-fall high time, in clock cycles
//   period_valid : one-cycle strobe when period_out/high_out update
//   locked       : period has repeated enough times to be considered stable
//   timeout      : no rising edge seen within the timeout window
// Modports: master drives sig_in and observes the results; slave is the meter.
interface pulse_period_meter_if;
   logic        sig_in;
   logic [31:0] period_out;
   logic [31:0] high_out;
   logic        period_valid;
   logic        locked;
   logic        timeout;

   modport master (
      output sig_in,
      input  period_out, high_out, period_valid, locked, timeout
   );

   modport slave (
      input  sig_in,
      output period_out, high_out, period_valid, locked, timeout
   );
endinterface

// File: rtl/pulse_period_meter.sv
// pulse_period_meter -- measures the period and high time of a slow square
// wave that is asynchronous to clk, and flags a stable period or a stalled input.
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   meter   : pulse_period_meter_if.slave
//             sig_in in; period_out, high_out, period_valid, locked, timeout out
// Parameters:
//   MAX_PERIOD : cycles without a rising edge before timeout (2..2^32-1)
//   LOCK_COUNT : consecutive equal periods needed to assert locked (1..15)
// Latency: a sig_in edge captured by the first synchronizer flop at edge k
// is acted on by the FSM at edge k+2, so period_valid is seen at edge k+3.
module pulse_period_meter #(
   parameter logic [31:0] MAX_PERIOD = 32'd1000000,
   parameter logic [3:0]  LOCK_COUNT = 4'd3
) (
   input logic                 clk,
   input logic                 reset_n,
   pulse_period_meter_if.slave meter
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      TOUT    = 2'd2
   } state_e;

   // Synchronizer and edge detector.
   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic rise;
   logic fall;

   // Measurement FSM.
   state_e      state_q;
   logic [31:0] cnt_q;
   logic [31:0] high_cnt_q;
   logic        fall_seen_q;   // first fall of this period already captured
   logic        have_prev_q;   // period_q holds a comparable earlier period
   logic [3:0]  match_q;
   logic [3:0]  match_d;

   // Registered outputs.
   logic [31:0] period_q;
   logic [31:0] high_q;
   logic        valid_q;
   logic        locked_q;
   logic        timeout_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make these three flops a true shift
         // chain; blocking ones would collapse it into a single flop.
         sync1_q <= meter.sig_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;

   // Match count the next publish would produce; period_q still holds the
   // previously published period when this is consumed.
   always_comb begin
      // NOTE: default assignment first, so no path leaves match_d unassigned
      // and no latch is inferred.
      match_d = 4'd0;
      if (have_prev_q && (cnt_q == period_q)) begin
         match_d = (match_q == 4'hF) ? 4'hF : match_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= 32'd0;
         high_cnt_q  <= 32'd0;
         fall_seen_q <= 1'b0;
         have_prev_q <= 1'b0;
         match_q     <= 4'd0;
         period_q    <= 32'd0;
         high_q      <= 32'd0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A fall here has no rise to pair with and is ignored.
               if (rise) begin
                  state_q     <= MEASURE;
                  cnt_q       <= 32'd1;
                  high_cnt_q  <= 32'd0;
                  fall_seen_q <= 1'b0;
               end
            end

            MEASURE: begin
               // A rise wins over the timeout check, so a period of exactly
               // MAX_PERIOD is still published.
               if (rise) begin
                  period_q    <= cnt_q;
                  high_q      <= high_cnt_q;
                  valid_q     <= 1'b1;
                  match_q     <= match_d;
                  locked_q    <= (match_d >= (LOCK_COUNT - 4'd1));
                  have_prev_q <= 1'b1;
                  cnt_q       <= 32'd1;
                  high_cnt_q  <= 32'd0;
                  fall_seen_q <= 1'b0;
               end else if (cnt_q == MAX_PERIOD) begin
                  // Stalled input: forget lock history, keep the last result.
                  state_q     <= TOUT;
                  timeout_q   <= 1'b1;
                  locked_q    <= 1'b0;
                  match_q     <= 4'd0;
                  have_prev_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
                  if (fall && !fall_seen_q) begin
                     high_cnt_q  <= cnt_q;
                     fall_seen_q <= 1'b1;
                  end
               end
            end

            TOUT: begin
               // cnt_q is frozen; the rise that ends the stall only restarts
               // measurement because there is no valid start point to pair it with.
               if (rise) begin
                  state_q     <= MEASURE;
                  timeout_q   <= 1'b0;
                  cnt_q       <= 32'd1;
                  high_cnt_q  <= 32'd0;
                  fall_seen_q <= 1'b0;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign meter.period_out   = period_q;
   assign meter.high_out     = high_q;
   assign meter.period_valid = valid_q;
   assign meter.locked       = locked_q;
   assign meter.timeout      = timeout_q;

endmodule
